// File: rtl/hit_shade_unit.sv
// hit_shade_unit: turns a ray-sphere intersection (hit, t) into a shaded pixel.
// It reconstructs the hit point P = O + t*D, the unit normal N = (P - C) * (1/r)
// and an 8-bit Lambert shade from N.L. All arithmetic is signed Q16.16.
// A small multi-cycle FSM shares one iterative restoring divider (1/r) across
// pixels. Valid/ready handshakes are used on both the input and output sides.
//
// Optional build macro:
//   SHADE_AMBIENT_EN - on the hit path, out_shade = max(AMBIENT, lambert).
//                      When undefined, the shade is the pure clamped Lambert term.
//
// Miss and degenerate-radius transactions zero P/N in MISS. They then pass through
// the SHADE stage, which selects BG_SHADE, so the miss result appears in DONE two
// cycles after accept.

module hit_shade_unit #(
    parameter logic [7:0] BG_SHADE = 8'd0,
    parameter logic [7:0] AMBIENT  = 8'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_hit,
    input  logic [31:0] in_t,
    input  logic [31:0] ox,
    input  logic [31:0] oy,
    input  logic [31:0] oz,
    input  logic [31:0] dx,
    input  logic [31:0] dy,
    input  logic [31:0] dz,
    input  logic [31:0] cx,
    input  logic [31:0] cy,
    input  logic [31:0] cz,
    input  logic [31:0] radius,
    input  logic [31:0] lx,
    input  logic [31:0] ly,
    input  logic [31:0] lz,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [31:0] px,
    output logic [31:0] py,
    output logic [31:0] pz,
    output logic [31:0] nx,
    output logic [31:0] ny,
    output logic [31:0] nz,
    output logic [7:0]  out_shade,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_CALC_P,
        S_CALC_N,
        S_DIV,
        S_NORM,
        S_SHADE,
        S_DONE
    } state_t;

    typedef logic [2:0][31:0] vec3_t;

    localparam logic [5:0]  DIV_LAST   = 6'd32;              // 33 quotient bits: 0..32
    localparam logic [32:0] DIV_DVD    = 33'h1_0000_0000;    // 2^32
    localparam logic [31:0] INV_SAT    = 32'h7FFF_FFFF;
    localparam logic [31:0] ONE_Q16    = 32'h0001_0000;

    // Q16.16 multiply: full signed product, arithmetic shift by 16, keep 32 bits.
    function automatic logic [31:0] qmul(input logic signed [31:0] a,
                                         input logic signed [31:0] b);
        logic signed [63:0] prod;
        prod = a * b;
        return prod[47:16];
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;

    logic        hit_q, hit_d;
    logic [31:0] t_q, t_d;
    logic [31:0] r_q, r_d;
    vec3_t       o_q, o_d;
    vec3_t       d_q, d_d;
    vec3_t       c_q, c_d;
    vec3_t       l_q, l_d;
    vec3_t       p_q, p_d;
    vec3_t       v_q, v_d;
    vec3_t       n_q, n_d;

    logic [32:0] div_dvd_q, div_dvd_d;
    logic [31:0] div_rem_q, div_rem_d;
    logic [32:0] div_quo_q, div_quo_d;
    logic [5:0]  div_cnt_q, div_cnt_d;

    logic        out_hit_q, out_hit_d;
    vec3_t       out_p_q, out_p_d;
    vec3_t       out_n_q, out_n_d;
    logic [7:0]  out_shade_q, out_shade_d;

    // Combinational helpers
    logic [32:0] rem_shift;
    logic        div_ge;
    logic [31:0] inv_r;
    logic [31:0] dot;
    logic [7:0]  lambert;
    logic [7:0]  lit_shade;

    // State register: the whole FSM returns to IDLE asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Datapath registers: latched inputs, work values, divider and output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q       <= 1'b0;
            t_q         <= '0;
            r_q         <= '0;
            o_q         <= '0;
            d_q         <= '0;
            c_q         <= '0;
            l_q         <= '0;
            p_q         <= '0;
            v_q         <= '0;
            n_q         <= '0;
            div_dvd_q   <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_cnt_q   <= '0;
            out_hit_q   <= 1'b0;
            out_p_q     <= '0;
            out_n_q     <= '0;
            out_shade_q <= BG_SHADE;
        end else begin
            hit_q       <= hit_d;
            t_q         <= t_d;
            r_q         <= r_d;
            o_q         <= o_d;
            d_q         <= d_d;
            c_q         <= c_d;
            l_q         <= l_d;
            p_q         <= p_d;
            v_q         <= v_d;
            n_q         <= n_d;
            div_dvd_q   <= div_dvd_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_cnt_q   <= div_cnt_d;
            out_hit_q   <= out_hit_d;
            out_p_q     <= out_p_d;
            out_n_q     <= out_n_d;
            out_shade_q <= out_shade_d;
        end
    end

    // Shared arithmetic: one divider step, saturated 1/r and the shade of N.L.
    always_comb begin
        // Restoring division step: bring in the next dividend bit, subtract if it fits.
        rem_shift = {div_rem_q, div_dvd_q[32]};
        div_ge    = (rem_shift >= {1'b0, r_q});
        inv_r     = (|div_quo_q[32:31]) ? INV_SAT : div_quo_q[31:0];

        dot = qmul(n_q[0], l_q[0]) + qmul(n_q[1], l_q[1]) + qmul(n_q[2], l_q[2]);
        if (dot[31]) begin
            lambert = 8'd0;
        end else if (dot >= ONE_Q16) begin
            lambert = 8'd255;
        end else begin
            lambert = dot[15:8];
        end

`ifdef SHADE_AMBIENT_EN
        lit_shade = (lambert < AMBIENT) ? AMBIENT : lambert;
`else
        lit_shade = lambert;
`endif
    end

`ifndef SHADE_AMBIENT_EN
    logic unused_ambient;
    assign unused_ambient = &{1'b0, AMBIENT};
`endif

    // Next-state and datapath next values for every FSM state.
    always_comb begin
        // NOTE: every _d starts as its _q so each path through the case assigns
        // it, which keeps this block purely combinational (no latches).
        state_d     = state_q;
        hit_d       = hit_q;
        t_d         = t_q;
        r_d         = r_q;
        o_d         = o_q;
        d_d         = d_q;
        c_d         = c_q;
        l_d         = l_q;
        p_d         = p_q;
        v_d         = v_q;
        n_d         = n_q;
        div_dvd_d   = div_dvd_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_cnt_d   = div_cnt_q;
        out_hit_d   = out_hit_q;
        out_p_d     = out_p_q;
        out_n_d     = out_n_q;
        out_shade_d = out_shade_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    hit_d = in_hit;
                    t_d   = in_t;
                    r_d   = radius;
                    o_d   = {oz, oy, ox};
                    d_d   = {dz, dy, dx};
                    c_d   = {cz, cy, cx};
                    l_d   = {lz, ly, lx};
                    if (!in_hit || $signed(radius) <= 0) begin
                        state_d = S_MISS;
                    end else begin
                        state_d = S_CALC_P;
                    end
                end
            end

            S_MISS: begin
                hit_d   = 1'b0;
                p_d     = '0;
                n_d     = '0;
                state_d = S_SHADE;
            end

            S_CALC_P: begin
                for (int i = 0; i < 3; i++) begin
                    p_d[i] = o_q[i] + qmul(t_q, d_q[i]);
                end
                state_d = S_CALC_N;
            end

            S_CALC_N: begin
                for (int i = 0; i < 3; i++) begin
                    v_d[i] = p_q[i] - c_q[i];
                end
                div_dvd_d = DIV_DVD;
                div_rem_d = '0;
                div_quo_d = '0;
                div_cnt_d = '0;
                state_d   = S_DIV;
            end

            S_DIV: begin
                div_dvd_d = {div_dvd_q[31:0], 1'b0};
                div_rem_d = div_ge ? 32'(rem_shift - {1'b0, r_q}) : rem_shift[31:0];
                div_quo_d = {div_quo_q[31:0], div_ge};
                div_cnt_d = div_cnt_q + 6'd1;
                if (div_cnt_q == DIV_LAST) begin
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                for (int i = 0; i < 3; i++) begin
                    n_d[i] = qmul(v_q[i], inv_r);
                end
                state_d = S_SHADE;
            end

            S_SHADE: begin
                // Output registers change only here, on the edge that enters DONE.
                out_hit_d   = hit_q;
                out_p_d     = p_q;
                out_n_d     = n_q;
                out_shade_d = hit_q ? lit_shade : BG_SHADE;
                state_d     = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_hit   = out_hit_q;
    assign px        = out_p_q[0];
    assign py        = out_p_q[1];
    assign pz        = out_p_q[2];
    assign nx        = out_n_q[0];
    assign ny        = out_n_q[1];
    assign nz        = out_n_q[2];
    assign out_shade = out_shade_q;

endmodule

// File: tb/tb_hit_shade_unit.sv
// Testbench for hit_shade_unit: directed cases plus randomized traffic.
// A driver pushes each expected result into a scoreboard queue.
// An independent monitor pops and compares on every output handshake.
// Build with +define+SHADE_AMBIENT_EN to check the ambient variant.

module tb_hit_shade_unit;

    localparam int BG      = 0;
    localparam int AMB     = 32;
    localparam int ONE     = 32'h0001_0000;

    typedef struct {
        bit hit;
        int t;
        int o[3];
        int d[3];
        int c[3];
        int r;
        int l[3];
    } stim_t;

    typedef struct {
        bit hit;
        int p[3];
        int n[3];
        int shade;
        int lat;
        int acc;
    } exp_t;

    typedef logic [7:0][31:0] outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_hit;
    logic [31:0] in_t, ox, oy, oz, dx, dy, dz, cx, cy, cz, radius, lx, ly, lz;
    logic        out_valid, out_ready, out_hit, busy;
    logic [31:0] px, py, pz, nx, ny, nz;
    logic [7:0]  out_shade;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    stall    = 0;
    bit    rand_bp  = 0;
    exp_t  sb[$];

    hit_shade_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit), .in_t(in_t),
        .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
        .cx(cx), .cy(cy), .cz(cz), .radius(radius), .lx(lx), .ly(ly), .lz(lz),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .px(px), .py(py), .pz(pz), .nx(nx), .ny(ny), .nz(nz),
        .out_shade(out_shade), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: forced low while stalling, optionally randomized.
    always @(posedge clk) begin
        #2;
        if (stall) out_ready = 1'b0;
        else if (rand_bp) out_ready = ($urandom % 3) != 0;
        else out_ready = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t cur_outs();
        return {32'(out_hit), px, py, pz, nx, ny, nz, 32'(out_shade)};
    endfunction

    // Q16.16 product as plain integer arithmetic.
    function automatic int qm(input int a, input int b);
        longint prod;
        prod = longint'(a) * longint'(b);
        return int'(prod >>> 16);
    endfunction

    // Reference model: what the pixel should be, computed directly from the geometry.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint inv;
        int     dot;
        int     lam;
        e.acc = 0;
        if (!s.hit || s.r <= 0) begin
            e.hit = 0;
            e.lat = 2;
            for (int i = 0; i < 3; i++) begin
                e.p[i] = 0;
                e.n[i] = 0;
            end
            e.shade = BG;
            return e;
        end
        e.hit = 1;
        e.lat = 37;
        inv = (longint'(1) <<< 32) / longint'(s.r);
        if (inv > 64'sh7FFF_FFFF) inv = 64'sh7FFF_FFFF;
        dot = 0;
        for (int i = 0; i < 3; i++) begin
            e.p[i] = s.o[i] + qm(s.t, s.d[i]);
            e.n[i] = qm(e.p[i] - s.c[i], int'(inv));
            dot    = dot + qm(e.n[i], s.l[i]);
        end
        if (dot < 0) lam = 0;
        else if (dot >= ONE) lam = 255;
        else lam = dot / 256;
`ifdef SHADE_AMBIENT_EN
        if (lam < AMB) lam = AMB;
`endif
        e.shade = lam;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        in_hit = s.hit;
        in_t   = s.t;
        ox = s.o[0]; oy = s.o[1]; oz = s.o[2];
        dx = s.d[0]; dy = s.d[1]; dz = s.d[2];
        cx = s.c[0]; cy = s.c[1]; cz = s.c[2];
        radius = s.r;
        lx = s.l[0]; ly = s.l[1]; lz = s.l[2];
    endtask

    // Present one transaction and wait (bounded) for it to be accepted.
    task automatic issue(input stim_t s, input bit track);
        exp_t e;
        bit   ok;
        ok = 0;
        @(posedge clk); #1;
        drive(s);
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        e     = model(s);
        e.acc = cyc + 1;
        if (track && ok) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic stim_t geom(input int t, input int r, input int lxv, input int lyv, input int lzv);
        stim_t s;
        s.hit = 1;
        s.t   = t;
        s.o[0] = 0; s.o[1] = 0; s.o[2] = 32'hFFFB_0000;   // (0,0,-5.0)
        s.d[0] = 0; s.d[1] = 0; s.d[2] = ONE;             // (0,0,1.0)
        s.c[0] = 0; s.c[1] = 0; s.c[2] = 0;
        s.r    = r;
        s.l[0] = lxv; s.l[1] = lyv; s.l[2] = lzv;
        return s;
    endfunction

    function automatic int srand(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    sel;
        s.hit = ($urandom % 5) != 0;
        s.t   = int'($urandom_range(0, 8 * ONE));
        for (int i = 0; i < 3; i++) begin
            s.o[i] = srand(8 * ONE);
            s.c[i] = srand(8 * ONE);
            s.d[i] = srand(ONE);
            s.l[i] = srand(ONE);
        end
        sel = int'($urandom % 10);
        if (sel == 0) s.r = -int'($urandom_range(0, 4 * ONE));
        else if (sel == 1) s.r = int'($urandom_range(1, 3));
        else s.r = int'($urandom_range(ONE / 4, 4 * ONE));
        return s;
    endfunction

    // Monitor: latency, stability while held, and values at each handshake.
    initial begin : monitor
        bit    prev;
        int    first;
        outs_t snap;
        outs_t now;
        exp_t  e;
        prev  = 0;
        first = 0;
        snap  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
            end else begin
                if (out_valid) begin
                    now = cur_outs();
                    if (!prev) begin
                        first = cyc;
                        snap  = now;
                    end else begin
                        check("held_stable", now[0] ^ now[1] ^ now[2] ^ now[3] ^ now[4] ^ now[5] ^ now[6] ^ now[7],
                              snap[0] ^ snap[1] ^ snap[2] ^ snap[3] ^ snap[4] ^ snap[5] ^ snap[6] ^ snap[7]);
                    end
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    check("busy_in_done", 32'(busy), 32'd1);
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            check("unexpected_output", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("latency", 32'(first - e.acc), 32'(e.lat));
                            check("out_hit", 32'(out_hit), 32'(e.hit));
                            check("px", px, e.p[0]);
                            check("py", py, e.p[1]);
                            check("pz", pz, e.p[2]);
                            check("nx", nx, e.n[0]);
                            check("ny", ny, e.n[1]);
                            check("nz", nz, e.n[2]);
                            check("out_shade", 32'(out_shade), 32'(e.shade));
                        end
                    end
                end
                prev = out_valid && !out_ready;
            end
        end
    end

    initial begin : driver
        stim_t s;
        outs_t snap;
        bit    ok;
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        s = geom(0, 0, 0, 0, 0);
        drive(s);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_p", px | py | pz, 32'd0);
        check("rst_n", nx | ny | nz, 32'd0);
        check("rst_shade", 32'(out_shade), 32'(BG));
        @(negedge clk);
        rst = 1'b0;

        // Frontal hit: P=(0,0,-1), N=(0,0,-1), lit head-on.
        issue(geom(4 * ONE, ONE, 0, 0, 32'hFFFF_0000), 1);
        drain();
        // Radius 2.0, light at grazing angle.
        issue(geom(3 * ONE, 2 * ONE, ONE, 0, 0), 1);
        drain();
        // Miss, zero radius and negative radius.
        s = geom(4 * ONE, ONE, 0, 0, 32'hFFFF_0000);
        s.hit = 0;
        issue(s, 1);
        drain();
        issue(geom(4 * ONE, 0, 0, 0, 32'hFFFF_0000), 1);
        drain();
        issue(geom(4 * ONE, 32'hFFFF_0000, 0, 0, 32'hFFFF_0000), 1);
        drain();
        // Half-lit: N.L = 0.5.
        issue(geom(4 * ONE, ONE, 0, 32'h0000_DDB3, 32'hFFFF_8000), 1);
        drain();
        // Saturated 1/r.
        issue(geom(4 * ONE, 1, 0, 0, 32'hFFFF_0000), 1);
        drain();

        // Back-pressure: hold out_ready low for 10 cycles and poke in_valid.
        stall = 1;
        issue(geom(4 * ONE, ONE, 0, 32'h0000_DDB3, 32'hFFFF_8000), 1);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("bp_valid_timeout", 32'd0, 32'd1);
        snap = cur_outs();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(rand_stim());
            in_valid = i[0];
            @(negedge clk);
            check("bp_outputs_held", 32'(cur_outs() == snap), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        stall = 0;
        @(posedge clk);
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset in the middle of division; the partial result must never appear.
        issue(geom(4 * ONE, ONE, 0, 0, 32'hFFFF_0000), 0);
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(geom(4 * ONE, ONE, 0, 32'h0000_DDB3, 32'hFFFF_8000), 1);
        drain();

        // Randomized traffic with random downstream back-pressure.
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            issue(rand_stim(), 1);
        end
        drain();
        rand_bp = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
